step_datapath: RTL
==================

# step_datapath

Datapath responder for the heater/counter control FSM: executes the per-cycle register-transfer commands the controller issues (s_en/s_zero/s_add/s_step for the 3-bit step register, y_en/y_store_x/y_select_next for the W-bit value register). It returns the y_inc status the controller samples in its count mode. It also exposes the register contents and status flags to the display logic. Sits directly below the control FSM; all command inputs arrive registered from it.

## Interface
- W, 8, width of value register y and load input x
- INC_AT, 3, step value whose arrival triggers y_inc (0..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_en  in  1  step register write enable
- s_zero  in  1  use 0 instead of s as adder base
- s_add  in  1  1: add step magnitude, 0: subtract
- s_step  in  2  step magnitude 0..3
- y_en  in  1  value register write enable
- y_store_x  in  1  load x into y (priority over select)
- y_select_next  in  2  next-value select: 0 hold, 1 y+1, 2 y-1, 3 clear
- x  in  W  external load value
- y_inc  out  1  step register will reach INC_AT on next increment
- s  out  3  step register
- y  out  W  value register
- y_zero  out  1  y == 0 (combinational)
- ovf  out  1  sticky wrap/limit flag

## Operation
- Step register, updated only when s_en=1: s <= base ± s_step, base = s_zero ? 0 : s, 3-bit modulo-8 arithmetic. Examples: zero,sub,2 -> 6; s=6,sub,2 -> 4; zero,step 0 -> 0; s=7,add,1 -> 0.
- s_en=0: s holds regardless of s_zero/s_add/s_step.
- y_inc = (s == INC_AT-1 mod 8), combinational from registered s; independent of command inputs.
- Value register, updated only when y_en=1: y_store_x=1 -> y <= x; else by y_select_next (0 hold, 1 y+1, 2 y-1, 3 0).
- y_en=0: y holds; y_store_x and y_select_next ignored.
- Increment from all-ones or decrement from 0 (see Configuration) sets ovf=1. ovf clears only on rst or on a y_store_x load (same edge, load wins over set).
- s and y commands are independent; both may update on the same edge.
- Reset values: s=0, y=0, ovf=0; hence y_inc=(INC_AT==1), y_zero=1.
- rst asserted mid-operation clears immediately (asynchronous); first update occurs at the first rising clk edge after rst deasserts.

## Timing
- All register updates on rising clk; one-cycle latency from command to s/y outputs.
- y_inc and y_zero follow s and y combinationally in the same cycle; no additional delay.
- The controller samples y_inc on the edge where it issues s+1; datapath guarantees y_inc is stable for the whole cycle after any s update.
- No handshake: every asserted enable is executed in the cycle presented; commands are never queued or dropped.

## Configuration
- STEP_DP_SAT_EN defined: y+1 at 2^W-1 and y-1 at 0 saturate (y unchanged), ovf set.
- Not defined: y wraps modulo 2^W (all-ones+1 -> 0, 0-1 -> all-ones), ovf set on wrap.
- Step register always wraps modulo 8 in both builds.

## Structure
- Shared package step_dp_pkg: select codes (SEL_HOLD=0, SEL_INC=1, SEL_DEC=2, SEL_CLR=3), step register width (3), default INC_AT.
- One sub-module, step_counter: 3-bit s register, base mux, add/sub adder, y_inc compare. Top level holds the y register, select mux, ovf logic and y_zero.

## Test plan
- Reset: assert rst mid-count with s=5, y=9 -> s=0, y=0, ovf=0, y_zero=1 without a clock edge.
- Step sequence: (zero,sub,2), (sub,2), (sub,2), (zero,step 0) -> s = 6, 4, 2, 0 on successive edges; s_en=0 cycle in between holds value.
- Count mode: s_add=1, s_step=1, s_en=1 for 10 cycles from s=0 -> y_inc high only while s=2, s wraps 7->0; y_en pulse on y_inc with select 1 -> y increments once per 8 cycles.
- Load priority: y_en=1, y_store_x=1, select=3, x=0x5A, ovf=1 -> y=0x5A, ovf=0.
- Limits, W=8: y=0xFF select 1 -> y=0x00, ovf=1 (no macro) / y=0xFF, ovf=1 (STEP_DP_SAT_EN); y=0 select 2 -> 0xFF / 0x00, ovf=1.
- Independence: simultaneous s_en (add 3) and y_en (select 2) from s=6, y=4 -> s=1, y=3 on one edge.

Source files
------------

// File: rtl/step_dp_pkg.sv
// Shared definitions for the step/value datapath that sits under the
// heater/counter control FSM: select codes for the value register,
// the step register width and the default y_inc trigger value.
package step_dp_pkg;

  localparam int STEP_W         = 3;
  localparam int DEFAULT_INC_AT = 3;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_DEC  = 2'd2,
    SEL_CLR  = 2'd3
  } sel_e;

endpackage

// File: rtl/step_counter.sv
// 3-bit step register with a selectable base (zero or current value),
// an add/subtract adder for a 0..3 magnitude, and the y_inc compare
// that tells the controller the next +1 lands on INC_AT.
module step_counter
  import step_dp_pkg::*;
#(
  parameter int INC_AT = DEFAULT_INC_AT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_en_i,
  input  logic              s_zero_i,
  input  logic              s_add_i,
  input  logic [1:0]        s_step_i,
  output logic [STEP_W-1:0] s_o,
  output logic              y_inc_o
);

  localparam logic [STEP_W-1:0] INC_MATCH = STEP_W'(INC_AT - 1);

  logic [STEP_W-1:0] s_q;
  logic [STEP_W-1:0] s_d;
  logic [STEP_W-1:0] stepBase;
  logic [STEP_W-1:0] stepMag;

  // Next step value: pick the base, then add or subtract the magnitude
  // modulo 8; without an enable the register simply holds.
  always_comb begin
    stepBase = s_zero_i ? '0 : s_q;
    stepMag  = STEP_W'(s_step_i);
    s_d      = s_q;
    if (s_en_i) begin
      s_d = s_add_i ? (stepBase + stepMag) : (stepBase - stepMag);
    end
  end

  // Step register, cleared asynchronously so the controller sees s=0
  // the moment reset is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s_o     = s_q;
  assign y_inc_o = (s_q == INC_MATCH);

endmodule

// File: rtl/step_datapath.sv
// Datapath responder for the heater/counter control FSM. Executes the
// per-cycle step and value register commands, reports y_inc back to
// the controller and exposes s, y, y_zero and the sticky ovf flag.
// Build option: define STEP_DP_SAT_EN to make y saturate at its limits
// instead of wrapping; ovf is set on either behaviour.
module step_datapath
  import step_dp_pkg::*;
#(
  parameter int W      = 8,
  parameter int INC_AT = DEFAULT_INC_AT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_en_i,
  input  logic              s_zero_i,
  input  logic              s_add_i,
  input  logic [1:0]        s_step_i,
  input  logic              y_en_i,
  input  logic              y_store_x_i,
  input  logic [1:0]        y_select_next_i,
  input  logic [W-1:0]      x_i,
  output logic              y_inc_o,
  output logic [STEP_W-1:0] s_o,
  output logic [W-1:0]      y_o,
  output logic              y_zero_o,
  output logic              ovf_o
);

  localparam logic [W-1:0] Y_ONES = '1;
  localparam logic [W-1:0] Y_ONE  = W'(1);

  logic [W-1:0] y_q;
  logic [W-1:0] y_d;
  logic         ovf_q;
  logic         ovf_d;
  sel_e         ySel;

  step_counter #(
    .INC_AT(INC_AT)
  ) u_step_counter (
    .clk      (clk),
    .rst      (rst),
    .s_en_i   (s_en_i),
    .s_zero_i (s_zero_i),
    .s_add_i  (s_add_i),
    .s_step_i (s_step_i),
    .s_o      (s_o),
    .y_inc_o  (y_inc_o)
  );

  assign ySel = sel_e'(y_select_next_i);

  // Next value and overflow: a load of x wins and also clears ovf;
  // otherwise the select code drives y, and stepping past either end
  // of the range raises ovf (wrapping or saturating by build option).
  always_comb begin
    y_d   = y_q;
    ovf_d = ovf_q;
    if (y_en_i) begin
      if (y_store_x_i) begin
        y_d   = x_i;
        ovf_d = 1'b0;
      end else begin
        case (ySel)
          SEL_INC: begin
            if (y_q == Y_ONES) begin
              ovf_d = 1'b1;
`ifdef STEP_DP_SAT_EN
              y_d   = y_q;
`else
              y_d   = '0;
`endif
            end else begin
              y_d = y_q + Y_ONE;
            end
          end
          SEL_DEC: begin
            if (y_q == '0) begin
              ovf_d = 1'b1;
`ifdef STEP_DP_SAT_EN
              y_d   = y_q;
`else
              y_d   = Y_ONES;
`endif
            end else begin
              y_d = y_q - Y_ONE;
            end
          end
          SEL_CLR: y_d = '0;
          default: y_d = y_q;
        endcase
      end
    end
  end

  // Value register and sticky overflow flag, both cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      ovf_q <= ovf_d;
    end
  end

  assign y_o      = y_q;
  assign ovf_o    = ovf_q;
  assign y_zero_o = (y_q == '0);

endmodule
